// File: rtl/eeprom_access_arbiter.sv
// Two-port arbiter in front of a single EEPROM read/write engine.
// Round-robin grant, address/protection check, bounded wait for completion.
module eeprom_access_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 12500000,
  parameter int unsigned PROT_BASE   = 240,
  parameter int unsigned CAL_BASE    = 240
) (
  input  logic          clk_125m,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  input  logic [1:0]    req_wr,
  input  logic [15:0]   req_addr,
  input  logic [127:0]  req_wdata,
  output logic [1:0]    req_ready,
  output logic [1:0]    resp_valid,
  output logic [63:0]   resp_rdata,
  output logic [1:0]    resp_err,
  input  logic          eeprom_idle,
  output logic          wr_req,
  output logic [7:0]    wr_addr,
  output logic [63:0]   wr_u64,
  input  logic          wr_done,
  output logic          rd_req,
  output logic [7:0]    rd_addr,
  input  logic [63:0]   rd_u64,
  input  logic          rd_done,
  output logic          busy,
  output logic [2:0]    dbg_state
);

  // Handshake: req_ready is a one-cycle pulse in IDLE for the granted port;
  // the request fields are captured on that same edge, so the requester may
  // drop req_valid right after. resp_valid is a one-cycle pulse, no back-pressure.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    WAIT_IDLE = 3'd2,
    ISSUE     = 3'd3,
    WAIT_DONE = 3'd4,
    RESP      = 3'd5
  } state_t;

  localparam logic [7:0]  PROT_ADDR = 8'(PROT_BASE);
  localparam logic [7:0]  CAL_ADDR  = 8'(CAL_BASE);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYC - 1);

  state_t       state_q, state_d;
  logic         prio_q, prio_d;
  logic         gnt_q, gnt_d;
  logic         wr_q, wr_d;
  logic [7:0]   addr_q, addr_d;
  logic [63:0]  wdata_q, wdata_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [1:0]   resp_valid_q, resp_valid_d;
  logic [1:0]   resp_err_q, resp_err_d;
  logic [63:0]  resp_rdata_q, resp_rdata_d;
  logic         wr_req_q, wr_req_d;
  logic         rd_req_q, rd_req_d;
  logic [7:0]   wr_addr_q, wr_addr_d;
  logic [7:0]   rd_addr_q, rd_addr_d;
  logic [63:0]  wr_u64_q, wr_u64_d;
  logic         grant_port;
  logic [1:0]   gnt_mask;

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    gnt_d        = gnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    resp_valid_d = 2'b00;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    wr_req_d     = 1'b0;
    rd_req_d     = 1'b0;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    wr_u64_d     = wr_u64_q;
    req_ready    = 2'b00;
    // On contention the priority pointer decides; otherwise the lone requester wins.
    grant_port   = (req_valid == 2'b11) ? prio_q : req_valid[1];
    gnt_mask     = gnt_q ? 2'b10 : 2'b01;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = grant_port ? 2'b10 : 2'b01;
          gnt_d     = grant_port;
          wr_d      = req_wr[grant_port];
          addr_d    = grant_port ? req_addr[15:8] : req_addr[7:0];
          wdata_d   = grant_port ? req_wdata[127:64] : req_wdata[63:0];
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (addr_q[2:0] != 3'd0) begin
          resp_err_d   = 2'd2;
          resp_rdata_d = '0;
          resp_valid_d = gnt_mask;
          state_d      = RESP;
        end else if (wr_q && (addr_q >= PROT_ADDR) && !(gnt_q && (addr_q == CAL_ADDR))) begin
          // Only the calibration port may rewrite the DAC power-on word.
          resp_err_d   = 2'd1;
          resp_rdata_d = '0;
          resp_valid_d = gnt_mask;
          state_d      = RESP;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (eeprom_idle) begin
          wr_req_d = wr_q;
          rd_req_d = !wr_q;
          if (wr_q) begin
            wr_addr_d = addr_q;
            wr_u64_d  = wdata_q;
          end else begin
            rd_addr_d = addr_q;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + 32'd1;
        if (wr_q ? wr_done : rd_done) begin
          resp_err_d   = 2'd0;
          resp_rdata_d = wr_q ? 64'd0 : rd_u64;
          resp_valid_d = gnt_mask;
          state_d      = RESP;
        end else if (cnt_d >= TO_LAST) begin
          resp_err_d   = 2'd3;
          resp_rdata_d = '0;
          resp_valid_d = gnt_mask;
          state_d      = RESP;
        end
      end
      RESP: begin
        prio_d  = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_125m) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      gnt_q        <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      resp_rdata_q <= '0;
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_u64_q     <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      gnt_q        <= gnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      wr_req_q     <= wr_req_d;
      rd_req_q     <= rd_req_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      wr_u64_q     <= wr_u64_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign wr_req     = wr_req_q;
  assign rd_req     = rd_req_q;
  assign wr_addr    = wr_addr_q;
  assign rd_addr    = rd_addr_q;
  assign wr_u64     = wr_u64_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// Directed bench for eeprom_access_arbiter: inputs driven on the falling edge,
// outputs checked on the falling edge, responses also collected into a scoreboard.
module tb_eeprom_access_arbiter;

  localparam int TO = 100;
  localparam logic [63:0] D0 = 64'h0123456789abcdef;

  logic          clk_125m = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_wr;
  logic [15:0]   req_addr;
  logic [127:0]  req_wdata;
  logic [1:0]    req_ready;
  logic [1:0]    resp_valid;
  logic [63:0]   resp_rdata;
  logic [1:0]    resp_err;
  logic          eeprom_idle;
  logic          wr_req;
  logic [7:0]    wr_addr;
  logic [63:0]   wr_u64;
  logic          wr_done;
  logic          rd_req;
  logic [7:0]    rd_addr;
  logic [63:0]   rd_u64;
  logic          rd_done;
  logic          busy;
  logic [2:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int ready_cnt = 0;
  int resp_cnt = 0;
  logic [67:0] exp_q[$];
  logic [67:0] obs_q[$];

  eeprom_access_arbiter #(.TIMEOUT_CYC(TO), .PROT_BASE(240), .CAL_BASE(240)) dut (
    .clk_125m(clk_125m), .rst_n(rst_n),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .eeprom_idle(eeprom_idle), .wr_req(wr_req), .wr_addr(wr_addr), .wr_u64(wr_u64),
    .wr_done(wr_done), .rd_req(rd_req), .rd_addr(rd_addr), .rd_u64(rd_u64), .rd_done(rd_done),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock/reset
  always #4 clk_125m = ~clk_125m;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // monitor
  always @(posedge clk_125m) begin
    if (wr_req === 1'b1) wr_cnt <= wr_cnt + 1;
    if (rd_req === 1'b1) rd_cnt <= rd_cnt + 1;
    if (req_ready !== 2'b00) ready_cnt <= ready_cnt + 1;
    if (resp_valid !== 2'b00) begin
      resp_cnt <= resp_cnt + 1;
      obs_q.push_back({resp_valid, resp_err, resp_rdata});
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk_125m);
  endtask

  // driver: request from port p; returns on the falling edge after acceptance
  task automatic send(input int p, input logic wr, input logic [7:0] addr, input logic [63:0] data);
    int n = 0;
    req_valid[p] = 1'b1;
    req_wr[p] = wr;
    req_addr[8*p +: 8] = addr;
    req_wdata[64*p +: 64] = data;
    #1;
    while (req_ready[p] !== 1'b1 && n < 50) begin
      @(negedge clk_125m);
      #1;
      n++;
    end
    chk("accept", req_ready[p], 1'b1);
    @(negedge clk_125m);
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_issue(input logic wr);
    int n = 0;
    while (((wr ? wr_req : rd_req) !== 1'b1) && n < 100) begin
      @(negedge clk_125m);
      n++;
    end
    chk(wr ? "wr_issue" : "rd_issue", wr ? wr_req : rd_req, 1'b1);
  endtask

  // engine: one done pulse, then the response must appear the next cycle
  task automatic ack(input logic wr, input logic [63:0] data, input logic [1:0] mask,
                     input logic [63:0] exp_rdata);
    @(negedge clk_125m);
    if (wr) wr_done = 1'b1; else rd_done = 1'b1;
    rd_u64 = data;
    @(negedge clk_125m);
    wr_done = 1'b0;
    rd_done = 1'b0;
    chk("ack_valid", resp_valid, mask);
    chk("ack_err", resp_err, 2'd0);
    chk("ack_rdata", resp_rdata, exp_rdata);
    exp_q.push_back({mask, 2'd0, exp_rdata});
  endtask

  // rejected request: response two cycles after accept, engine untouched
  task automatic err_case(input int p, input logic wr, input logic [7:0] addr,
                          input logic [1:0] exp_err);
    int w = wr_cnt;
    int r = rd_cnt;
    logic [1:0] m = (p == 0) ? 2'b01 : 2'b10;
    send(p, wr, addr, 64'hdead_beef_0000_0000);
    @(negedge clk_125m);
    chk("err_valid", resp_valid, m);
    chk("err_code", resp_err, exp_err);
    chk("err_rdata", resp_rdata, 64'd0);
    exp_q.push_back({m, exp_err, 64'd0});
    @(negedge clk_125m);
    chk("err_no_issue", {wr_cnt - w, rd_cnt - r}, 64'd0);
  endtask

  initial begin
    int n;
    int c;
    logic [1:0] m;
    logic [63:0] dat;
    rst_n = 1'b0;
    req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    eeprom_idle = 1'b1; wr_done = 1'b0; rd_done = 1'b0; rd_u64 = D0;
    wait_neg(3);
    chk("rst_ctrl", {req_ready, resp_valid, wr_req, rd_req, busy}, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_addr", {wr_addr, rd_addr}, 0);
    chk("rst_wdata", wr_u64, 0);
    chk("rst_state", dbg_state, 3'd0);
    rst_n = 1'b1;
    wait_neg(2);

    // port 0 write, slow engine, stray rd_done ignored
    c = wr_cnt;
    send(0, 1'b1, 8'd16, D0);
    wait_issue(1'b1);
    chk("w_addr", wr_addr, 8'd16);
    chk("w_data", wr_u64, D0);
    chk("w_busy", busy, 1'b1);
    @(negedge clk_125m);
    chk("w_pulse", wr_req, 1'b0);
    wait_neg(20);
    rd_done = 1'b1;
    @(negedge clk_125m);
    rd_done = 1'b0;
    chk("w_wrong_done", resp_valid, 2'b00);
    wait_neg(27);
    ack(1'b1, 64'd0, 2'b01, 64'd0);
    chk("w_one_req", wr_cnt - c, 1);

    // port 0 read, engine busy for a while first
    eeprom_idle = 1'b0;
    send(0, 1'b0, 8'd16, 64'd0);
    wait_neg(5);
    chk("ri_hold", rd_req, 1'b0);
    chk("ri_state", dbg_state, 3'd2);
    eeprom_idle = 1'b1;
    wait_issue(1'b0);
    chk("r_addr", rd_addr, 8'd16);
    chk("r_wr_addr_held", wr_addr, 8'd16);
    wait_neg(3);
    ack(1'b0, D0, 2'b01, D0);

    // protection and alignment
    err_case(0, 1'b1, 8'd240, 2'd1);
    err_case(1, 1'b1, 8'd248, 2'd1);
    err_case(0, 1'b0, 8'd19, 2'd2);
    err_case(1, 1'b1, 8'd241, 2'd2);
    send(1, 1'b1, 8'd240, 64'hcafe_f00d_1234_5678);
    wait_issue(1'b1);
    chk("cal_addr", wr_addr, 8'd240);
    chk("cal_data", wr_u64, 64'hcafe_f00d_1234_5678);
    ack(1'b1, 64'd0, 2'b10, 64'd0);
    send(0, 1'b1, 8'd232, 64'h5555_aaaa_5555_aaaa);
    wait_issue(1'b1);
    chk("below_prot_addr", wr_addr, 8'd232);
    ack(1'b1, 64'd0, 2'b01, 64'd0);
    send(1, 1'b0, 8'd248, 64'd0);
    wait_issue(1'b0);
    chk("prot_read_addr", rd_addr, 8'd248);
    ack(1'b0, 64'hfedc_ba98_7654_3210, 2'b10, 64'hfedc_ba98_7654_3210);

    // both ports held: grants alternate, back-to-back
    @(negedge clk_125m);
    c = resp_cnt;
    n = ready_cnt;
    req_wr = 2'b00;
    req_addr = {8'd64, 8'd8};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      m = (k % 2 == 0) ? 2'b01 : 2'b10;
      dat = (k % 2 == 0) ? 64'h1111_0000_1111_0000 : 64'h2222_0000_2222_0000;
      #1;
      chk("rr_grant", req_ready, m);
      @(negedge clk_125m);
      wait_issue(1'b0);
      chk("rr_addr", rd_addr, (k % 2 == 0) ? 8'd8 : 8'd64);
      ack(1'b0, dat, m, dat);
      if (k == 3) req_valid = 2'b00;
      @(negedge clk_125m);
    end
    chk("rr_ready_cnt", ready_cnt - n, 4);
    chk("rr_resp_cnt", resp_cnt - c, 4);

    // timeout: no done pulse
    send(0, 1'b0, 8'd0, 64'd0);
    wait_issue(1'b0);
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 200) begin
      @(negedge clk_125m);
      n++;
    end
    chk("to_latency", n, TO);
    chk("to_err", resp_err, 2'd3);
    chk("to_rdata", resp_rdata, 64'd0);
    exp_q.push_back({2'b01, 2'd3, 64'd0});
    @(negedge clk_125m);

    // scoreboard
    chk("sb_count", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk("sb_resp", obs_q.pop_front(), exp_q.pop_front());

    // reset during WAIT_DONE
    send(0, 1'b1, 8'd24, D0);
    wait_issue(1'b1);
    wait_neg(10);
    rst_n = 1'b0;
    @(negedge clk_125m);
    chk("mid_rst_ctrl", {req_ready, resp_valid, wr_req, rd_req, busy}, 0);
    chk("mid_rst_err", resp_err, 0);
    chk("mid_rst_addr", {wr_addr, rd_addr}, 0);
    chk("mid_rst_data", {wr_u64, resp_rdata}, 0);
    @(negedge clk_125m);
    rst_n = 1'b1;
    c = resp_cnt;
    wait_neg(150);
    chk("mid_rst_no_resp", resp_cnt - c, 0);
    wr_done = 1'b1;
    rd_done = 1'b1;
    @(negedge clk_125m);
    wr_done = 1'b0;
    rd_done = 1'b0;
    @(negedge clk_125m);
    chk("idle_done_ignored", {resp_valid, busy}, 0);
    req_valid = 2'b11;
    #1;
    chk("rst_prio", req_ready, 2'b01);
    req_valid = 2'b00;
    wait_neg(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
